// File: rtl/Verdata_pkg.sv
// Shared data types for the Vergister register file and the units around it.
package Verdata_pkg;

    localparam int WORD_WIDTH  = 32;
    localparam int INDEX_WIDTH = 5;

    typedef logic [WORD_WIDTH-1:0]  word_t;
    typedef logic [INDEX_WIDTH-1:0] register_index_t;

    // Decoded instruction fields the register file cares about.
    typedef struct packed {
        logic [6:0]      opcode;
        register_index_t rd;
        logic            has_rd;
        register_index_t rs1;
        register_index_t rs2;
    } instruction_t;

    // One debug-port register access, shared with the debug module.
    typedef struct packed {
        logic            write;
        register_index_t index;
        word_t           wdata;
    } dbg_request_t;

endpackage

// File: rtl/Veropcodes_pkg.sv
// Opcode constants and canned instructions.
package Veropcodes_pkg;

    import Verdata_pkg::*;

    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    // addi x0, x0, 0: touches no register and writes nothing.
    localparam instruction_t INSTR_NOP = '{
        opcode: OPCODE_OP_IMM,
        rd:     '0,
        has_rd: 1'b0,
        rs1:    '0,
        rs2:    '0
    };

endpackage

// File: rtl/vergister_arbiter.sv
// Shares the Vergister register file between the CPU pipeline and the debug
// port. The pipeline owns the file by default; a debug request stalls it,
// borrows the file for a single access cycle, then hands it back.
module vergister_arbiter
    import Verdata_pkg::*;
    import Veropcodes_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  instruction_t cpu_src_instr,
    input  instruction_t cpu_dest_instr,
    input  word_t        cpu_xd,
    input  logic         cpu_enable,
    output logic         cpu_stall,
    input  logic         dbg_valid,
    input  logic         dbg_write,
    input  logic [$bits(register_index_t)-1:0] dbg_index,
    input  word_t        dbg_wdata,
    output logic         dbg_ready,
    output logic         dbg_rvalid,
    output word_t        dbg_rdata,
    output logic         regs_enable,
    output instruction_t regs_src_instr,
    output instruction_t regs_dest_instr,
    output word_t        regs_xd,
    input  word_t        regs_xs1
);

    localparam int unsigned INDEX_SPAN = 1 << $bits(register_index_t);

    // The index type has to be able to address every register.
    if (SIZE < 1 || SIZE > INDEX_SPAN) begin : g_badSize
        $error("vergister_arbiter: SIZE does not fit register_index_t");
    end

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } arb_state_t;

    arb_state_t   r_state;
    arb_state_t   w_nextState;
    logic         r_stall;
    logic         r_rvalid;
    word_t        r_rdata;
    dbg_request_t w_dbgReq;
    logic         w_dbgAccess;
    logic         w_dbgRead;

    assign w_dbgReq = '{write: dbg_write, index: dbg_index, wdata: dbg_wdata};

    // A request only counts if it is still valid in the grant cycle.
    assign w_dbgAccess = (r_state == GRANT) && dbg_valid;
    assign w_dbgRead   = w_dbgAccess && !w_dbgReq.write;

    assign cpu_stall  = r_stall;
    assign dbg_rvalid = r_rvalid;
    assign dbg_rdata  = r_rdata;

    // State register; reset always returns ownership to the pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Grant and release each last exactly one cycle, so the pipeline always gets an idle cycle between debug accesses.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (dbg_valid) w_nextState = GRANT;
            GRANT:   w_nextState = RELEASE;
            RELEASE: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Register-file port mux: pipeline pass-through in IDLE, debug access in GRANT, write-disabled pipeline view in RELEASE.
    always_comb begin
        regs_src_instr  = cpu_src_instr;
        regs_dest_instr = cpu_dest_instr;
        regs_xd         = cpu_xd;
        regs_enable     = 1'b0;
        dbg_ready       = 1'b0;
        case (r_state)
            IDLE: begin
                regs_enable = cpu_enable;
            end
            GRANT: begin
                regs_src_instr         = INSTR_NOP;
                regs_src_instr.rs1     = w_dbgReq.index;
                regs_dest_instr        = INSTR_NOP;
                regs_dest_instr.rd     = w_dbgReq.index;
                regs_dest_instr.has_rd = (w_dbgReq.index != '0);
                regs_xd                = w_dbgReq.wdata;
                regs_enable            = w_dbgAccess && w_dbgReq.write;
                dbg_ready              = w_dbgAccess;
            end
            default: begin
            end
        endcase
    end

    // Registered stall, read-valid pulse and the captured read data, which is held until the next read completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall  <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_stall  <= (w_nextState != IDLE);
            r_rvalid <= w_dbgRead;
            if (w_dbgRead) begin
                r_rdata <= regs_xs1;
            end
        end
    end

endmodule

// File: tb/tb_vergister_arbiter.sv
// Self-checking bench for vergister_arbiter: directed scenarios with literal
// expectations, then random pipeline traffic and debug requests checked every
// cycle against a timeline model of the debug access.
module tb_vergister_arbiter;

    import Verdata_pkg::*;
    import Veropcodes_pkg::*;

    localparam int SIZE       = 32;
    localparam int MAX_CYCLES = 5000;

    logic            clk = 1'b0;
    logic            reset;
    instruction_t    cpu_src_instr;
    instruction_t    cpu_dest_instr;
    word_t           cpu_xd;
    logic            cpu_enable;
    logic            cpu_stall;
    logic            dbg_valid;
    logic            dbg_write;
    register_index_t dbg_index;
    word_t           dbg_wdata;
    logic            dbg_ready;
    logic            dbg_rvalid;
    word_t           dbg_rdata;
    logic            regs_enable;
    instruction_t    regs_src_instr;
    instruction_t    regs_dest_instr;
    word_t           regs_xd;
    word_t           regs_xs1;

    int checkCount = 0;
    int failCount  = 0;

    // envRegs stands in for the Vergister instance; refRegs is the model's view.
    word_t envRegs [SIZE] = '{default: '0};
    word_t refRegs [SIZE] = '{default: '0};

    always #5 clk = ~clk;

    vergister_arbiter #(.SIZE(SIZE)) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_src_instr   (cpu_src_instr),
        .cpu_dest_instr  (cpu_dest_instr),
        .cpu_xd          (cpu_xd),
        .cpu_enable      (cpu_enable),
        .cpu_stall       (cpu_stall),
        .dbg_valid       (dbg_valid),
        .dbg_write       (dbg_write),
        .dbg_index       (dbg_index),
        .dbg_wdata       (dbg_wdata),
        .dbg_ready       (dbg_ready),
        .dbg_rvalid      (dbg_rvalid),
        .dbg_rdata       (dbg_rdata),
        .regs_enable     (regs_enable),
        .regs_src_instr  (regs_src_instr),
        .regs_dest_instr (regs_dest_instr),
        .regs_xd         (regs_xd),
        .regs_xs1        (regs_xs1)
    );

    // Register file stand-in: combinational read with x0 hard-wired to zero.
    always_comb begin
        regs_xs1 = (regs_src_instr.rs1 == '0) ? '0 : envRegs[regs_src_instr.rs1];
    end

    // Register file stand-in: write on the clock edge when enabled.
    always @(posedge clk) begin
        if (!reset && regs_enable && regs_dest_instr.has_rd) begin
            envRegs[regs_dest_instr.rd] <= regs_xd;
        end
    end

    function automatic logic [31:0] toWord(input instruction_t i);
        return {{(32 - $bits(instruction_t)){1'b0}}, i};
    endfunction

    function automatic logic [31:0] bitWord(input logic b);
        return {31'd0, b};
    endfunction

    function automatic instruction_t mkSrc(input register_index_t rs1);
        instruction_t t;
        t     = INSTR_NOP;
        t.rs1 = rs1;
        return t;
    endfunction

    function automatic instruction_t mkDest(input register_index_t rd);
        instruction_t t;
        t        = INSTR_NOP;
        t.rd     = rd;
        t.has_rd = 1'b1;
        return t;
    endfunction

    function automatic word_t refRead(input register_index_t i);
        return (i == '0) ? '0 : refRegs[i];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle of inputs, driven just after the rising edge.
    task automatic applyStimulus(input instruction_t src, input instruction_t dest, input word_t xd,
                                 input logic en, input logic dv, input logic dw,
                                 input register_index_t di, input word_t dd);
        @(posedge clk);
        #1;
        cpu_src_instr  = src;
        cpu_dest_instr = dest;
        cpu_xd         = xd;
        cpu_enable     = en;
        dbg_valid      = dv;
        dbg_write      = dw;
        dbg_index      = di;
        dbg_wdata      = dd;
    endtask

    task automatic idleCycle();
        applyStimulus(INSTR_NOP, INSTR_NOP, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic cpuWrite(input register_index_t rd, input word_t data);
        applyStimulus(INSTR_NOP, mkDest(rd), data, 1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic cpuRead(input register_index_t rs1);
        applyStimulus(mkSrc(rs1), INSTR_NOP, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Full debug access: request raised in an idle cycle, ready one cycle
    // later, read data valid the cycle after that. The pipeline write given
    // here is presented (and held, as a stalled pipeline would) alongside.
    task automatic dbgTransaction(input logic w, input register_index_t idx, input word_t data,
                                  input logic cpuEn, input register_index_t cpuRd, input word_t cpuData,
                                  output word_t seenRdata);
        instruction_t dest;
        dest = cpuEn ? mkDest(cpuRd) : INSTR_NOP;
        applyStimulus(INSTR_NOP, dest, cpuData, cpuEn, 1'b1, w, idx, data);
        @(negedge clk);
        checkOutput("txRequestReady", bitWord(dbg_ready), 32'd0);
        checkOutput("txRequestStall", bitWord(cpu_stall), 32'd0);
        applyStimulus(INSTR_NOP, dest, cpuData, cpuEn, 1'b1, w, idx, data);
        @(negedge clk);
        checkOutput("txGrantReady", bitWord(dbg_ready), 32'd1);
        checkOutput("txGrantStall", bitWord(cpu_stall), 32'd1);
        checkOutput("txGrantEnable", bitWord(regs_enable), bitWord(w));
        idleCycle();
        @(negedge clk);
        checkOutput("txReleaseStall", bitWord(cpu_stall), 32'd1);
        checkOutput("txReleaseReady", bitWord(dbg_ready), 32'd0);
        checkOutput("txReleaseRvalid", bitWord(dbg_rvalid), bitWord(!w));
        seenRdata = dbg_rdata;
    endtask

    // Reference model: position 0 means the pipeline owns the file, 1 is the
    // debug access cycle, 2 is the hand-back cycle.
    int           slot        = 0;
    int           nextSlot;
    logic         pendingRead = 1'b0;
    word_t        expRdata    = '0;
    instruction_t expSrc;
    instruction_t expDest;
    word_t        expXd;
    logic         expEnable;
    logic         expReady;
    logic         expRvalid;
    logic         checkDest;

    // Every cycle: compare all outputs to the model, then advance it.
    always @(negedge clk) begin
        if (reset) begin
            checkOutput("rstStall", bitWord(cpu_stall), 32'd0);
            checkOutput("rstReady", bitWord(dbg_ready), 32'd0);
            checkOutput("rstRvalid", bitWord(dbg_rvalid), 32'd0);
            checkOutput("rstRdata", dbg_rdata, 32'd0);
            checkOutput("rstEnable", bitWord(regs_enable), bitWord(cpu_enable));
            checkOutput("rstSrc", toWord(regs_src_instr), toWord(cpu_src_instr));
            slot        = 0;
            pendingRead = 1'b0;
            expRdata    = '0;
        end else begin
            expSrc    = cpu_src_instr;
            expDest   = cpu_dest_instr;
            expXd     = cpu_xd;
            expEnable = 1'b0;
            expReady  = 1'b0;
            expRvalid = 1'b0;
            checkDest = 1'b0;
            nextSlot  = 0;
            if (slot == 0) begin
                expEnable = cpu_enable;
                checkDest = 1'b1;
                nextSlot  = dbg_valid ? 1 : 0;
            end else if (slot == 1) begin
                expSrc     = mkSrc(dbg_index);
                expReady   = dbg_valid;
                expEnable  = dbg_valid && dbg_write;
                if (expEnable) begin
                    expDest        = INSTR_NOP;
                    expDest.rd     = dbg_index;
                    expDest.has_rd = (dbg_index != '0);
                    expXd          = dbg_wdata;
                    checkDest      = 1'b1;
                end
                nextSlot = 2;
            end else begin
                expRvalid = pendingRead;
                nextSlot  = 0;
            end

            checkOutput("modelStall", bitWord(cpu_stall), bitWord(slot != 0));
            checkOutput("modelReady", bitWord(dbg_ready), bitWord(expReady));
            checkOutput("modelRvalid", bitWord(dbg_rvalid), bitWord(expRvalid));
            checkOutput("modelRdata", dbg_rdata, expRdata);
            checkOutput("modelEnable", bitWord(regs_enable), bitWord(expEnable));
            checkOutput("modelSrc", toWord(regs_src_instr), toWord(expSrc));
            checkOutput("modelXs1", regs_xs1, refRead(expSrc.rs1));
            if (checkDest) begin
                checkOutput("modelDest", toWord(regs_dest_instr), toWord(expDest));
                checkOutput("modelXd", regs_xd, expXd);
            end

            if (expEnable && expDest.has_rd) begin
                refRegs[expDest.rd] = expXd;
            end
            if (slot == 1) begin
                pendingRead = dbg_valid && !dbg_write;
                if (pendingRead) begin
                    expRdata = refRead(dbg_index);
                end
            end else begin
                pendingRead = 1'b0;
            end
            slot = nextSlot;
        end
    end

    // Back-to-back table: two writes presented without a gap.
    logic stallExp [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic readyExp [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    word_t           seen;
    logic            reqActive;
    logic            reqW;
    register_index_t reqIdx;
    word_t           reqData;
    int              waited;
    logic            sawReady;
    instruction_t    rndSrc;
    instruction_t    rndDest;

    // Directed scenarios followed by random traffic.
    initial begin
        reset          = 1'b1;
        cpu_src_instr  = INSTR_NOP;
        cpu_dest_instr = INSTR_NOP;
        cpu_xd         = '0;
        cpu_enable     = 1'b0;
        dbg_valid      = 1'b0;
        dbg_write      = 1'b0;
        dbg_index      = '0;
        dbg_wdata      = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Pipeline pass-through.
        cpuWrite(5'd5, 32'h0000_6000);
        @(negedge clk);
        checkOutput("passWriteStall", bitWord(cpu_stall), 32'd0);
        cpuRead(5'd5);
        @(negedge clk);
        checkOutput("passReadX5", regs_xs1, 32'h0000_6000);
        checkOutput("passReadStall", bitWord(cpu_stall), 32'd0);

        // Debug write, then pipeline read.
        dbgTransaction(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, '0, '0, seen);
        cpuRead(5'd7);
        @(negedge clk);
        checkOutput("dbgWriteReadX7", regs_xs1, 32'hDEAD_BEEF);
        checkOutput("dbgWriteStallLow", bitWord(cpu_stall), 32'd0);

        // Debug reads, including x0 after an attempted write to it.
        cpuWrite(5'd3, 32'h0000_4000);
        dbgTransaction(1'b0, 5'd3, '0, 1'b0, '0, '0, seen);
        checkOutput("dbgReadX3", seen, 32'h0000_4000);
        dbgTransaction(1'b1, 5'd0, 32'h0000_1234, 1'b0, '0, '0, seen);
        dbgTransaction(1'b0, 5'd0, '0, 1'b0, '0, '0, seen);
        checkOutput("dbgReadX0", seen, 32'd0);

        // Request raised in the same cycle as a pipeline write.
        dbgTransaction(1'b0, 5'd9, '0, 1'b1, 5'd9, 32'h0000_9000, seen);
        checkOutput("simulReadX9", seen, 32'h0000_9000);

        // Reset during the grant cycle of a write.
        cpuWrite(5'd4, 32'h0000_1111);
        applyStimulus(INSTR_NOP, INSTR_NOP, '0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_FFFF);
        applyStimulus(INSTR_NOP, INSTR_NOP, '0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_FFFF);
        #1;
        checkOutput("rstMidGrantReady", bitWord(dbg_ready), 32'd1);
        checkOutput("rstMidRdataBefore", dbg_rdata, 32'h0000_9000);
        reset = 1'b1;
        #1;
        checkOutput("rstMidStall", bitWord(cpu_stall), 32'd0);
        checkOutput("rstMidReady", bitWord(dbg_ready), 32'd0);
        checkOutput("rstMidRvalid", bitWord(dbg_rvalid), 32'd0);
        checkOutput("rstMidRdata", dbg_rdata, 32'd0);
        idleCycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            @(negedge clk);
            checkOutput("rstMidNoRvalid", bitWord(dbg_rvalid), 32'd0);
        end
        cpuRead(5'd4);
        @(negedge clk);
        checkOutput("rstMidX4Kept", regs_xs1, 32'h0000_1111);

        // Back-to-back debug writes.
        for (int i = 0; i < 7; i++) begin
            if (i < 2) begin
                applyStimulus(INSTR_NOP, INSTR_NOP, '0, 1'b0, 1'b1, 1'b1, 5'd10, 32'h0000_0111);
            end else if (i < 5) begin
                applyStimulus(INSTR_NOP, INSTR_NOP, '0, 1'b0, 1'b1, 1'b1, 5'd11, 32'h0000_0222);
            end else begin
                idleCycle();
            end
            @(negedge clk);
            checkOutput("b2bStall", bitWord(cpu_stall), bitWord(stallExp[i]));
            checkOutput("b2bReady", bitWord(dbg_ready), bitWord(readyExp[i]));
        end
        cpuRead(5'd10);
        @(negedge clk);
        checkOutput("b2bX10", regs_xs1, 32'h0000_0111);
        cpuRead(5'd11);
        @(negedge clk);
        checkOutput("b2bX11", regs_xs1, 32'h0000_0222);

        // Random pipeline traffic with protocol-respecting debug requests.
        reqActive = 1'b0;
        sawReady  = 1'b0;
        waited    = 0;
        reqW      = 1'b0;
        reqIdx    = '0;
        reqData   = '0;
        for (int i = 0; i < 800; i++) begin
            if (reqActive && sawReady) begin
                checkOutput("randReadyLatency", bitWord(waited <= 2), 32'd1);
                reqActive = 1'b0;
            end else if (reqActive && waited > 3) begin
                checkOutput("randReadyTimeout", bitWord(dbg_ready), 32'd1);
                reqActive = 1'b0;
            end
            if (!reqActive && $urandom_range(0, 2) == 0) begin
                reqActive = 1'b1;
                reqW      = 1'($urandom_range(0, 1));
                reqIdx    = register_index_t'($urandom_range(0, SIZE - 1));
                reqData   = $urandom;
                waited    = 0;
            end
            rndSrc         = mkSrc(register_index_t'($urandom_range(0, SIZE - 1)));
            rndDest        = INSTR_NOP;
            rndDest.rd     = register_index_t'($urandom_range(0, SIZE - 1));
            rndDest.has_rd = 1'($urandom_range(0, 1));
            applyStimulus(rndSrc, rndDest, $urandom, 1'($urandom_range(0, 1)),
                          reqActive, reqActive ? reqW : 1'($urandom_range(0, 1)),
                          reqActive ? reqIdx : register_index_t'($urandom_range(0, SIZE - 1)),
                          reqActive ? reqData : $urandom);
            @(negedge clk);
            sawReady = dbg_ready;
            if (reqActive && !sawReady) begin
                waited++;
            end
        end

        repeat (3) idleCycle();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

    // Hard stop in case the run never reaches its summary.
    initial begin
        #(MAX_CYCLES * 10);
        $display("[TB] FAIL watchdog: simulation exceeded %0d cycles", MAX_CYCLES);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/vergister_arbiter.md
# vergister_arbiter

Arbiter that shares the `Vergister` register file between the CPU pipeline and a debug access port. The pipeline owns the register file by default. A debug request stalls the pipeline, takes over the register file for one access cycle, then hands it back. It sits between the pipeline's decode/writeback signals and the `Vergister` instance, replacing their direct connection.

## Interface

Parameters:
- `SIZE`, default 32: number of registers, matching `Vergister.SIZE`; `register_index_t` must cover it.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `cpu_src_instr`  in  `instruction_t`  pipeline decode-stage instruction (rs1/rs2).
- `cpu_dest_instr`  in  `instruction_t`  pipeline writeback instruction (has_rd/rd).
- `cpu_xd`  in  `word_t`  pipeline writeback data.
- `cpu_enable`  in  1  pipeline register-file write enable.
- `cpu_stall`  out  1  registered; pipeline must hold all state while high.
- `dbg_valid`  in  1  debug request valid.
- `dbg_write`  in  1  1 = write, 0 = read.
- `dbg_index`  in  `register_index_t`  target register.
- `dbg_wdata`  in  `word_t`  write data.
- `dbg_ready`  out  1  one-cycle pulse; the request is accepted on this cycle.
- `dbg_rvalid`  out  1  one-cycle pulse; `dbg_rdata` is valid.
- `dbg_rdata`  out  `word_t`  captured read data, held until the next read completes.
- `regs_enable`, `regs_src_instr`, `regs_dest_instr`, `regs_xd`  out  to `Vergister`.
- `regs_xs1`  in  `word_t`  from `Vergister` (combinational read).

## Operation

States are IDLE, GRANT and RELEASE.

**IDLE**
- Register-file outputs pass through from the `cpu_*` inputs.
- If `dbg_valid`=1, go to GRANT. The pipeline's access in this cycle still completes, which drains any in-flight write.

**GRANT**
- `regs_src_instr` = `INSTR_NOP` with rs1 = `dbg_index`.
- Write request:
  - `regs_dest_instr` = `INSTR_NOP` with rd = `dbg_index` and has_rd = (`dbg_index` != 0).
  - `regs_xd` = `dbg_wdata`, `regs_enable` = 1.
- Read request: `regs_enable` = 0, and `dbg_rdata` captures `regs_xs1` at the clock edge.
- `dbg_ready` = 1 (combinational from state and `dbg_valid`).
- Always go to RELEASE.
- If `dbg_valid`=0 in GRANT (protocol violation): no access, no `dbg_ready`, go to RELEASE.

**RELEASE**
- `regs_src_instr` = `cpu_src_instr`, `regs_enable` = 0.
- `dbg_rvalid` = 1 if the GRANT access was a read.
- Always go to IDLE.

**Rules**
- The pipeline always gets at least one IDLE cycle between debug accesses; debug cannot starve it.
- `cpu_enable` is ignored outside IDLE.
- The requester holds `dbg_write`, `dbg_index` and `dbg_wdata` stable from `dbg_valid` rise until `dbg_ready`.
- Writes to x0 are accepted and discarded. Reads of x0 return 0.

## Timing

- **Reset** (async, any state): state = IDLE, `cpu_stall` = 0, `dbg_ready` = 0, `dbg_rvalid` = 0, `dbg_rdata` = 0.
- **`cpu_stall`** is registered: high during GRANT and RELEASE, low in IDLE.
- **Read latency:** `dbg_valid` rising in cycle N gives `dbg_ready` in N+1 and `dbg_rvalid`/`dbg_rdata` in N+2.
- **Write latency:** the register is updated at the end of N+1 and is readable by the pipeline in N+3.
- **Back-to-back requests:** at most one debug access per 3 cycles.
- **Reset during GRANT:** a write is not performed if reset is asserted before the edge, and no `dbg_rvalid` follows.

## Structure

- `Verdata_pkg` gains `dbg_request_t`, a struct of write, index and wdata, shared with the future debug module.
- The arbiter state enum is local to the module.
- `INSTR_NOP` comes from `Veropcodes_pkg`.
- No sub-module: one FSM with an output mux.

## Test plan

- **CPU pass-through:** no debug request; CPU writes x5 = 0x6000, then reads rs1 = 5. Required: xs1 = 0x6000 and `cpu_stall` stays 0.
- **Debug write, then CPU read:** debug writes x7 = 0xDEADBEEF. Required: `dbg_ready` 1 cycle after valid, `cpu_stall` high for 2 cycles, then a CPU read of x7 returns 0xDEADBEEF.
- **Debug read:** x3 preloaded with 0x4000; debug reads x3. Required: `dbg_rvalid` 2 cycles after valid with `dbg_rdata` = 0x4000. A debug read of x0 returns 0 even after a debug write of 0x1234 to x0.
- **Simultaneous request:** `dbg_valid` rises in the same cycle as a CPU write of x9 = 0x9000, and debug reads x9. Required: `dbg_rdata` = 0x9000.
- **Back-to-back requests:** two consecutive debug writes. Required: `cpu_stall` drops for exactly one IDLE cycle between them, and `dbg_ready` pulses are 3 cycles apart.
- **Reset mid-access:** assert reset during GRANT of a write to x4 = 0xFFFF. Required: all outputs return to reset values immediately, x4 is unchanged, and no `dbg_rvalid` follows.
